// File: rtl/regwr_arbiter.sv
// Write-port arbiter/sequencer for the 32 x 8-bit register file: round-robin grant with burst lock.
// Optional build macro REGWR_FIXED_PRIO_EN switches IDLE arbitration to fixed lowest-index priority.
module regwr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     wr_req,
  input  logic [NUM_REQ-1:0]     wr_lock,
  input  logic [NUM_REQ*5-1:0]   wr_addr,
  input  logic [NUM_REQ*8-1:0]   wr_data,
  output logic [NUM_REQ-1:0]     wr_gnt,
  input  logic [255:0]           regfile_out,
  output logic [31:0]            regloads,
  output logic [7:0]             regfile_in,
  output logic                   busy,
  output logic [2:0]             lock_owner
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [31:0] R31_SEL = 32'h8000_0000;

  state_t       state_q, state_d;
  logic [2:0]   rr_ptr_q, rr_ptr_d;
  logic [2:0]   lock_owner_q, lock_owner_d;
  logic [7:0]   lock_cnt_q, lock_cnt_d;
  logic [31:0]  regloads_q, regloads_d;
  logic [7:0]   data_q, data_d;
  logic         refresh_q, refresh_d;
  logic         busy_q, busy_d;

  logic [NUM_REQ-1:0] gnt_s;
  logic [2:0]   lo_s, hi_s, win_s, sel_s;
  logic         hit_lo_s, hit_hi_s;
  logic         xfer_s, sel_lock_s;
  logic [4:0]   sel_addr_s;
  logic [7:0]   sel_data_s;
  logic         unused_regfile_s;

  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    onehot32 = 32'd1 << idx;
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] idx);
    if (int'(idx) >= NUM_REQ - 1) begin
      next_ptr = 3'd0;
    end else begin
      next_ptr = idx + 3'd1;
    end
  endfunction

  // Grant selection: owner-only while locked, otherwise first request at or above rr_ptr, wrapping.
  always_comb begin
    gnt_s    = '0;
    lo_s     = 3'd0;
    hi_s     = 3'd0;
    hit_lo_s = 1'b0;
    hit_hi_s = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      lo_s     = wr_req[k] ? 3'(k) : lo_s;
      hit_lo_s = hit_lo_s | wr_req[k];
      hi_s     = (wr_req[k] && (3'(k) >= rr_ptr_q)) ? 3'(k) : hi_s;
      hit_hi_s = hit_hi_s | (wr_req[k] && (3'(k) >= rr_ptr_q));
    end
`ifdef REGWR_FIXED_PRIO_EN
    win_s = lo_s;
`else
    win_s = hit_hi_s ? hi_s : lo_s;
`endif
    if (rst) begin
      gnt_s = '0;
    end else if (state_q == LOCKED) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        gnt_s[k] = wr_req[k] && (3'(k) == lock_owner_q);
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        gnt_s[k] = hit_lo_s && (3'(k) == win_s);
      end
    end
  end

  // Transfer payload mux from the single granted requester.
  always_comb begin
    xfer_s     = |gnt_s;
    sel_s      = 3'd0;
    sel_addr_s = 5'd0;
    sel_data_s = 8'd0;
    sel_lock_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_s      = gnt_s[k] ? 3'(k) : sel_s;
      sel_addr_s = gnt_s[k] ? wr_addr[5*k +: 5] : sel_addr_s;
      sel_data_s = gnt_s[k] ? wr_data[8*k +: 8] : sel_data_s;
      sel_lock_s = gnt_s[k] ? wr_lock[k] : sel_lock_s;
    end
  end

  // Next-state: write sequencing (refresh of R31 when idle) and lock FSM with idle timeout.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    regloads_d   = R31_SEL;
    refresh_d    = 1'b1;
    data_d       = data_q;
    if (xfer_s) begin
      regloads_d = onehot32(sel_addr_s);
      data_d     = sel_data_s;
      refresh_d  = 1'b0;
`ifdef REGWR_FIXED_PRIO_EN
      rr_ptr_d   = 3'd0;
`else
      rr_ptr_d   = next_ptr(sel_s);
`endif
    end else begin
      rr_ptr_d   = rr_ptr_q;
    end
    case (state_q)
      IDLE: begin
        if (xfer_s && sel_lock_s) begin
          state_d      = LOCKED;
          lock_owner_d = sel_s;
          lock_cnt_d   = 8'd0;
        end else begin
          state_d      = IDLE;
          lock_owner_d = 3'd0;
          lock_cnt_d   = 8'd0;
        end
      end
      LOCKED: begin
        if (xfer_s && sel_lock_s) begin
          lock_cnt_d   = 8'd0;
        end else if (xfer_s || (lock_cnt_q == 8'(LOCK_TIMEOUT - 1))) begin
          state_d      = IDLE;
          lock_owner_d = 3'd0;
          lock_cnt_d   = 8'd0;
        end else begin
          lock_cnt_d   = lock_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d      = IDLE;
        lock_owner_d = 3'd0;
        lock_cnt_d   = 8'd0;
      end
    endcase
    busy_d = (state_d == LOCKED);
  end

  // State and output registers; reset replaces any in-flight write with the R31 refresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 3'd0;
      lock_owner_q <= 3'd0;
      lock_cnt_q   <= 8'd0;
      regloads_q   <= R31_SEL;
      data_q       <= 8'd0;
      refresh_q    <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      regloads_q   <= regloads_d;
      data_q       <= data_d;
      refresh_q    <= refresh_d;
      busy_q       <= busy_d;
    end
  end

  // Refresh uses the live R31 so a write committed on the previous edge is preserved.
  assign regfile_in       = refresh_q ? regfile_out[255:248] : data_q;
  assign regloads         = regloads_q;
  assign wr_gnt           = gnt_s;
  assign busy             = busy_q;
  assign lock_owner       = lock_owner_q;
  assign unused_regfile_s = ^regfile_out[247:0];

endmodule

// File: doc/regwr_arbiter.md
Name: regwr_arbiter

Overview:
- Write-port arbiter and sequencer for the 32 x 8-bit register file.
- Shares the file's single write port between NUM_REQ requesters (ALU writeback, load unit, immediate loader, debug) using round-robin arbitration, with an optional multi-cycle lock for burst writes.
- Drives the file's one-hot regloads and regfile_in; the file commits regfile_in into the selected register on every clock edge, and any non-one-hot code commits to R31.
- When no write is in flight, the arbiter issues a refresh write of R31 with its own current value, so no register is corrupted.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 15, idle cycles after which a held lock is force-released (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_req  in  NUM_REQ  per-requester write request (valid).
- wr_lock  in  NUM_REQ  per-requester lock request, sampled on a transfer.
- wr_addr  in  NUM_REQ*5  target register index; requester i uses bits [5i+4:5i].
- wr_data  in  NUM_REQ*8  write data; requester i uses bits [8i+7:8i].
- wr_gnt  out  NUM_REQ  combinational grant (ready); transfer occurs when wr_req[i] and wr_gnt[i] are both high at a clock edge.
- regfile_out  in  256  register file contents; R31 is bits [255:248].
- regloads  out  32  one-hot register select to the file.
- regfile_in  out  8  write data to the file.
- busy  out  1  high while in LOCKED state.
- lock_owner  out  3  index of the lock holder; 0 when not LOCKED.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, lock_cnt=0, busy=0, lock_owner=0.
  - regloads=32'h8000_0000, refresh flag=1, wr_gnt=0.
- Grant: at most one wr_gnt bit is high; it is combinational from wr_req, state, rr_ptr and lock_owner; no grant while rst=1.
- IDLE arbitration: search from rr_ptr upward with wrap-around to NUM_REQ-1 then 0. The first asserted wr_req wins.
- On a transfer by requester i:
  - rr_ptr <= (i+1) mod NUM_REQ.
  - regloads <= one-hot(wr_addr_i).
  - data register <= wr_data_i.
  - refresh flag <= 0.
- Latency: the transfer at edge t drives regloads/regfile_in during cycle t+1, and the file commits at edge t+1. Back-to-back transfers are allowed every cycle.
- No transfer at edge t:
  - Cycle t+1 carries regloads=32'h8000_0000, refresh flag=1.
  - regfile_in is combinationally regfile_out[255:248] while the refresh flag is set. This uses the live value, so a write to R31 committed at edge t is preserved.
- regfile_in is the registered data when the refresh flag is 0.
- Entering the lock: a transfer by i with wr_lock[i]=1 moves the FSM from IDLE to LOCKED, with lock_owner=i, busy=1 and lock_cnt=0.
- LOCKED state:
  - Only lock_owner can be granted; it is granted whenever wr_req[owner]=1.
  - A transfer with wr_lock[owner]=1 stays LOCKED and clears lock_cnt.
  - A transfer with wr_lock[owner]=0 returns to IDLE.
  - A cycle with no owner request increments lock_cnt. When lock_cnt reaches LOCK_TIMEOUT-1 with no request, the next edge forces IDLE, busy=0, lock_owner=0.
  - rr_ptr still advances past the owner on each of its transfers.
- Simultaneous requests to the same address from different requesters are serialized in round-robin order; the last committed write wins.
- A requester may change wr_addr/wr_data only after its transfer edge or while wr_req=0. The arbiter does not latch inputs before the transfer.
- Reset mid-operation:
  - An in-flight regloads (a transfer already taken) is replaced by the R31 refresh immediately and asynchronously.
  - The lock is dropped.
  - The requester's transfer is considered accepted; it is not retried.

Optional Feature:
- Macro: REGWR_FIXED_PRIO_EN.
- Defined: IDLE arbitration is fixed priority; the lowest asserted index wins, and rr_ptr is held at 0 and ignored. Lock behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then hold no requests for 3 cycles -> regloads=32'h8000_0000 each cycle and regfile_in tracks regfile_out[255:248]; R31=8'h5A stays 8'h5A.
- wr_req=4'b1111 for 4 cycles, addresses 1,2,3,4 and data 8'h11..8'h44 -> grants in order 0,1,2,3, one per cycle, no repeats; regloads 32'h2, 32'h4, 32'h8, 32'h10 in consecutive cycles, each one cycle after its grant.
- Requester 2 writes R31=8'hA5, then 1 idle cycle -> refresh writes 8'hA5, not the stale value.
- Requester 1 transfers with wr_lock=1, requesters 0 and 3 keep requesting -> busy=1, lock_owner=1; only 1 is granted until it transfers with wr_lock=0; then 3 is granted before 0 (rr_ptr=2).
- Lock held, owner idle for 15 cycles -> busy drops after the 15th idle cycle and pending requester 0 is granted the following cycle.
- Assert rst while regloads=32'h4 is in flight -> regloads becomes 32'h8000_0000 asynchronously and wr_gnt=0.
- With REGWR_FIXED_PRIO_EN defined, wr_req=4'b1010 held -> requester 1 is granted every cycle.
